// File: rtl/kmp_pkg.sv
// kmp_pkg: shared state encoding and default sizes for the KMP stream matcher
package kmp_pkg;
   typedef enum logic [3:0] {IDLE = 4'd0, BUILD = 4'd1, SEARCH = 4'd2, DONE = 4'd3} state_t;
   localparam int DATA_W_DEF  = 8;
   localparam int PAT_MAX_DEF = 8;
   localparam int POS_W_DEF   = 14;
   localparam int CNT_W_DEF   = 8;
endpackage

// File: rtl/kmp_fail_table.sv
// kmp_fail_table: pattern store, failure table and one-step-per-cycle table builder
module kmp_fail_table
   import kmp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [LEN_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              init,
   input  logic              step_en,
   input  logic [LEN_W-1:0]  len,
   input  logic [LEN_W-1:0]  q,
   input  logic [LEN_W-1:0]  fidx,
   output logic [DATA_W-1:0] pat_q,
   output logic [LEN_W-1:0]  fail_q,
   output logic              build_done
);
   localparam int DEPTH = 2 ** LEN_W;
   logic [DATA_W-1:0] pat_mem [DEPTH];
   logic [LEN_W-1:0] fail_mem [DEPTH];
   logic [LEN_W-1:0] i, k, i_nxt, k_nxt;
   logic hit, wr;
   assign hit = pat_mem[i] == pat_mem[k];
   assign wr = i != len && (hit || k == '0);
   assign i_nxt = wr ? i + 1'b1 : i;
   assign k_nxt = i == len ? k : hit ? k + 1'b1 : k != '0 ? fail_mem[k - 1'b1] : k;
   // finishing on the step that reaches len makes BUILD take len-1 cycles at best
   assign build_done = i_nxt == len;
   assign pat_q = pat_mem[q];
   assign fail_q = fail_mem[fidx];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int j = 0; j < DEPTH; j++) begin
            pat_mem[j] <= '0;
            fail_mem[j] <= '0;
         end
         i <= '0;
         k <= '0;
      end else begin
         if (we) pat_mem[waddr] <= wdata;
         if (init) begin
            fail_mem[0] <= '0;
            i <= LEN_W'(1);
            k <= '0;
         end else if (step_en) begin
            if (wr) fail_mem[i] <= hit ? k + 1'b1 : '0;
            i <= i_nxt;
            k <= k_nxt;
         end
      end
endmodule

// File: rtl/kmp_stream_matcher.sv
// kmp_stream_matcher: runtime-loaded KMP matcher over a valid/ready text stream
module kmp_stream_matcher
   import kmp_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PAT_MAX = PAT_MAX_DEF,
   parameter int LEN_W   = $clog2(PAT_MAX + 1),
   parameter int POS_W   = POS_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pat_we,
   input  logic [LEN_W-1:0]  pat_addr,
   input  logic [DATA_W-1:0] pat_data,
   input  logic [LEN_W-1:0]  pat_len,
   input  logic              overlap,
   input  logic              start,
   input  logic              abort,
   input  logic              text_valid,
   input  logic [DATA_W-1:0] text_data,
   input  logic              text_last,
   output logic              text_ready,
   output logic              match_valid,
   output logic [POS_W-1:0]  match_pos,
   output logic [CNT_W-1:0]  match_count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        actual_state
);
   state_t state, state_nxt;
   logic [LEN_W-1:0] len_r, q, q_nxt, fidx, fail_q;
   logic [DATA_W-1:0] hold_d, pat_q;
   logic [POS_W-1:0] pos;
   logic hold_v, hold_last, ovl_r, idle_like, go, bad, srch, eq, consume, back, full, accept, build_done;
   assign idle_like = state == IDLE || state == DONE;
   assign go = start && !abort && idle_like;
   assign bad = pat_len == '0 || pat_len > LEN_W'(PAT_MAX);
   assign srch = state == SEARCH && !abort && hold_v;
   assign eq = hold_d == pat_q;
   assign consume = srch && (eq || q == '0);
   assign back = srch && !eq && q != '0;
   assign full = eq && q + 1'b1 == len_r;
   // one failure-table read port serves both backtrack and post-match restart
   assign fidx = eq ? len_r - 1'b1 : q - 1'b1;
   assign q_nxt = back ? fail_q : !eq ? '0 : full ? (ovl_r ? fail_q : '0) : q + 1'b1;
   assign text_ready = state == SEARCH && (!hold_v || consume) && !(consume && hold_last);
   assign accept = text_valid && text_ready;
   assign busy = state == BUILD || state == SEARCH;
   assign done = state == DONE;
   assign actual_state = state;
   kmp_fail_table #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_tab (
      .clk(clk),
      .rst(rst),
      .we(pat_we && idle_like && pat_addr < LEN_W'(PAT_MAX)),
      .waddr(pat_addr),
      .wdata(pat_data),
      .init(go && !bad),
      .step_en(state == BUILD && !abort),
      .len(len_r),
      .q(q),
      .fidx(fidx),
      .pat_q(pat_q),
      .fail_q(fail_q),
      .build_done(build_done)
   );
   always_comb begin
      state_nxt = abort ? IDLE :
                  go ? (bad ? DONE : BUILD) :
                  state == BUILD && build_done ? SEARCH :
                  consume && hold_last ? DONE : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         len_r <= '0;
         ovl_r <= 1'b0;
         q <= '0;
         hold_v <= 1'b0;
         hold_d <= '0;
         hold_last <= 1'b0;
         pos <= '0;
         match_count <= '0;
         match_valid <= 1'b0;
         match_pos <= '0;
         err <= 1'b0;
      end else begin
         match_valid <= consume && full;
         if (consume && full) begin
            match_pos <= pos - POS_W'(len_r) + 1'b1;
            match_count <= match_count == '1 ? match_count : match_count + 1'b1;
         end
         if (consume) pos <= pos + 1'b1;
         if (consume || back) q <= q_nxt;
         if (abort || go) hold_v <= 1'b0;
         else if (accept) begin
            hold_v <= 1'b1;
            hold_d <= text_data;
            hold_last <= text_last;
         end else if (consume) hold_v <= 1'b0;
         if (go) begin
            len_r <= pat_len;
            ovl_r <= overlap;
            q <= '0;
            pos <= '0;
            match_count <= '0;
            err <= bad;
         end
      end
endmodule

// File: tb/tb_kmp_stream_matcher.sv
// tb_kmp_stream_matcher: directed and random runs checked against a brute-force match model
module tb_kmp_stream_matcher;
   logic clk = 0, rst = 1;
   logic pat_we = 0, overlap = 0, start = 0, abort = 0, text_valid = 0, text_last = 0;
   logic [3:0] pat_addr = '0, pat_len = '0;
   logic [7:0] pat_data = '0, text_data = '0;
   logic text_ready, match_valid, busy, done, err;
   logic [13:0] match_pos;
   logic [3:0] match_count, actual_state;
   int tests = 0, fails = 0, stalls = 0, base, nb, wd, rl, rt;
   int got[$], exp_q[$];
   logic [7:0] pat_a [8];
   logic [7:0] txt [64];
   int exp_f [6] = '{0, 1, 0, 1, 2, 2};
   bit ok;

   kmp_stream_matcher #(.DATA_W(8), .PAT_MAX(8), .POS_W(14), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
      .pat_len(pat_len), .overlap(overlap), .start(start), .abort(abort),
      .text_valid(text_valid), .text_data(text_data), .text_last(text_last),
      .text_ready(text_ready), .match_valid(match_valid), .match_pos(match_pos),
      .match_count(match_count), .busy(busy), .done(done), .err(err), .actual_state(actual_state)
   );

   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (match_valid) got.push_back(int'(match_pos));
      if (text_valid && !text_ready && actual_state == 4'd2) stalls++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model(input int len, input bit ovl, input int tlen);
      int last_end = -1;
      bit m;
      exp_q = {};
      for (int s = 0; s + len <= tlen; s++) begin
         m = 1;
         for (int j = 0; j < len; j++) if (txt[s + j] != pat_a[j]) m = 0;
         if (m && (ovl || s > last_end)) begin
            exp_q.push_back(s);
            last_end = s + len - 1;
         end
      end
   endfunction

   function automatic int build_cycles(input int len);
      int fl[8];
      int i = 1, k = 0, n = 0;
      fl[0] = 0;
      while (i < len) begin
         n++;
         if (pat_a[i] == pat_a[k]) begin k++; fl[i] = k; i++; end
         else if (k > 0) k = fl[k - 1];
         else begin fl[i] = 0; i++; end
      end
      return n == 0 ? 1 : n;
   endfunction

   task automatic load_pat(input int len);
      for (int j = 0; j < len; j++) begin
         pat_we = 1; pat_addr = 4'(j); pat_data = pat_a[j];
         @(posedge clk); #1;
      end
      pat_we = 0;
   endtask

   task automatic go(input int len, input bit ovl);
      pat_len = 4'(len); overlap = ovl; start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic pulse_abort();
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
   endtask

   task automatic send(input logic [7:0] d, input logic l, output bit acc);
      int w = 0;
      text_valid = 1; text_data = d; text_last = l; acc = 0;
      while (!acc && w < 100) begin
         @(negedge clk); acc = text_ready;
         @(posedge clk); #1; w++;
      end
      text_valid = 0; text_last = 0;
   endtask

   task automatic run(input int len, input bit ovl, input int tlen, input bit gap, input string tag);
      int b, w, n;
      bit a;
      load_pat(len);
      b = got.size();
      go(len, ovl);
      for (int t = 0; t < tlen; t++) begin
         if (gap && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         send(txt[t], t == tlen - 1, a);
         if (!a) begin
            check($sformatf("%s ready timeout", tag), 0, 1);
            return;
         end
      end
      w = 0;
      while (!done && w < 200) begin @(negedge clk); w++; end
      repeat (2) @(negedge clk);
      model(len, ovl, tlen);
      check($sformatf("%s done", tag), done, 1);
      check($sformatf("%s err", tag), err, 0);
      check($sformatf("%s count", tag), match_count, exp_q.size() > 15 ? 15 : exp_q.size());
      check($sformatf("%s pulses", tag), got.size() - b, exp_q.size());
      n = got.size() - b < exp_q.size() ? got.size() - b : exp_q.size();
      for (int j = 0; j < n; j++) check($sformatf("%s pos%0d", tag, j), got[b + j], exp_q[j]);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst state", actual_state, 0);
      check("rst count", match_count, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst err", err, 0);
      check("rst ready", text_ready, 0);
      check("rst mvalid", match_valid, 0);
      rst = 0;
      @(posedge clk); #1;

      pat_a[0] = "A"; pat_a[1] = "B"; pat_a[2] = "A"; pat_a[3] = "B";
      for (int t = 0; t < 6; t++) txt[t] = t % 2 ? "B" : "A";
      run(4, 1, 6, 0, "abab_ovl");
      run(4, 0, 6, 0, "abab_novl");

      pat_a[0] = "A"; pat_a[1] = "A"; pat_a[2] = "B"; pat_a[3] = "A"; pat_a[4] = "A"; pat_a[5] = "A";
      load_pat(6);
      go(6, 1);
      nb = 0; wd = 0;
      @(negedge clk);
      while (actual_state == 4'd1 && wd < 50) begin nb++; wd++; @(negedge clk); end
      check("build cycles", nb, build_cycles(6));
      for (int j = 0; j < 6; j++) check($sformatf("fail[%0d]", j), dut.u_tab.fail_mem[j], exp_f[j]);
      pulse_abort();

      pat_a[0] = "A"; pat_a[1] = "A"; pat_a[2] = "A"; pat_a[3] = "B";
      for (int t = 0; t < 4; t++) txt[t] = "A";
      txt[4] = "B";
      base = stalls;
      run(4, 1, 5, 0, "aaab");
      check("aaab stalls", stalls - base, 1);

      base = got.size();
      go(0, 1);
      @(negedge clk);
      check("len0 err", err, 1);
      check("len0 done", done, 1);
      check("len0 count", match_count, 0);
      go(9, 1);
      @(negedge clk);
      check("len9 err", err, 1);
      check("len9 done", done, 1);
      check("len9 count", match_count, 0);
      repeat (2) @(negedge clk);
      check("bad len pulses", got.size() - base, 0);

      pat_a[0] = "A";
      for (int t = 0; t < 20; t++) txt[t] = "A";
      run(1, 1, 20, 0, "sat");

      repeat (25) begin
         rl = $urandom_range(1, 8);
         rt = $urandom_range(8, 40);
         for (int j = 0; j < rl; j++) pat_a[j] = 8'h41 + 8'($urandom_range(0, 1));
         for (int t = 0; t < rt; t++) txt[t] = 8'h41 + 8'($urandom_range(0, 1));
         run(rl, 1'($urandom_range(0, 1)), rt, 1, "rand");
      end

      pat_a[0] = "A"; pat_a[1] = "B";
      load_pat(2);
      go(2, 1);
      for (int t = 0; t < 4; t++) send(t % 2 ? "B" : "A", 0, ok);
      repeat (3) begin @(posedge clk); #1; end
      check("pre-rst count", match_count, 2);
      check("pre-rst state", actual_state, 2);
      @(negedge clk); #2 rst = 1; #1;
      check("mid-rst count", match_count, 0);
      check("mid-rst state", actual_state, 0);
      check("mid-rst busy", busy, 0);
      check("mid-rst ready", text_ready, 0);
      check("mid-rst pos", match_pos, 0);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;

      pat_a[0] = "A";
      load_pat(1);
      go(1, 0);
      for (int t = 0; t < 5; t++) send("A", 0, ok);
      repeat (3) begin @(posedge clk); #1; end
      check("pre-abort count", match_count, 5);
      pulse_abort();
      @(negedge clk);
      check("abort state", actual_state, 0);
      check("abort count", match_count, 5);
      check("abort mvalid", match_valid, 0);
      @(posedge clk); #1;
      go(1, 0);
      @(negedge clk);
      check("restart count", match_count, 0);
      check("restart state", actual_state, 1);
      @(posedge clk); #1;
      pulse_abort();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/kmp_stream_matcher.md
Name: kmp_stream_matcher

Overview:
Parametrised successor to the fixed 4-character KMP matcher. It holds a runtime-loadable pattern of up to PAT_MAX symbols and builds the KMP failure table in hardware. It then searches a streamed text under a valid/ready handshake, reporting every match (overlapping or not), its position and a saturating count. It sits between the text source (ROM reader or UART) and the display/counter logic.

Parameters:
DATA_W, 8, symbol width in bits
PAT_MAX, 8, maximum pattern length (must be 2 or more)
LEN_W, $clog2(PAT_MAX+1), width of pattern length and state index
POS_W, 14, text position counter width
CNT_W, 8, match counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
pat_we  in  1  pattern write strobe; honoured only in IDLE or DONE
pat_addr  in  LEN_W  pattern write index; writes with index PAT_MAX or above are ignored
pat_data  in  DATA_W  pattern symbol
pat_len  in  LEN_W  pattern length, latched on start
overlap  in  1  1 = overlapping matches, 0 = non-overlapping; latched on start
start  in  1  one-cycle pulse; begins build and search from IDLE or DONE
abort  in  1  synchronous return to IDLE; count and position are kept
text_valid  in  1  text symbol valid
text_data  in  DATA_W  text symbol
text_last  in  1  marks the final symbol of the text
text_ready  out  1  symbol accepted when text_valid and text_ready are both high
match_valid  out  1  one-cycle pulse per match
match_pos  out  POS_W  0-based stream index of the first symbol of the match
match_count  out  CNT_W  number of matches, saturating
busy  out  1  high in BUILD or SEARCH
done  out  1  high in DONE
err  out  1  invalid pat_len at start; held until the next start
actual_state  out  4  current FSM state code, for LEDs/debug

Behaviour:
- Reset: every output, pattern memory, failure table, counters and hold register go to 0; state is IDLE. Reset mid-operation aborts immediately.
- States and encoding: IDLE=0, BUILD=1, SEARCH=2, DONE=3.
- IDLE/DONE + start:
  - Clear match_count, position, q and err.
  - If pat_len is 0 or greater than PAT_MAX: set err and go to DONE next cycle.
  - Otherwise go to BUILD.
- start, pat_we and pat_len changes during BUILD or SEARCH are ignored.
- BUILD: fail[0]=0, i=1, k=0. Exactly one step per cycle:
  - pat[i]==pat[k]: fail[i]=k+1, k++, i++.
  - else if k>0: k=fail[k-1].
  - else: fail[i]=0, i++.
  - When i==len, go to SEARCH. For len=1, BUILD lasts exactly 1 cycle. In general it takes len-1 to 2(len-1) cycles, minimum 1.
- SEARCH: a one-entry hold register stores the current symbol; q is the number of pattern symbols currently matched.
  - text_ready = (state==SEARCH) and (hold empty, or hold consumed this cycle). It has no combinational path from text_valid or text_data.
  - Hold symbol equals pat[q]: consume it, q++.
  - Mismatch with q>0: q=fail[q-1]; symbol stays held; costs 1 cycle.
  - Mismatch with q=0: consume the symbol.
  - Every consumed symbol increments the position counter, which wraps at 2^POS_W.
- Match: q reaches len on consume.
  - Next cycle: match_valid=1 and match_pos = consumed index - len + 1 (mod 2^POS_W).
  - match_count increments and saturates at 2^CNT_W-1.
  - q becomes fail[len-1] if overlap=1, otherwise 0.
- Throughput: 1 symbol per cycle when no backtrack occurs.
- Last symbol: when the text_last symbol is consumed, any match it completes is still reported; then the FSM goes to DONE. A backtracking symbol is not consumed until it resolves.
- DONE: holds match_count, done and err; match_valid=0. A new start re-runs using the stored pattern.
- abort: wins over every other event; next state is IDLE, the hold register is emptied, and match_valid is forced to 0.

Decomposition:
- Package kmp_pkg: state enum typedef and encodings, default parameter constants.
- Sub-module kmp_fail_table: pattern storage, failure storage and the BUILD sequencer. It exposes pat[q], fail[idx] and build_done.
- Top level: FSM, hold register, position and match counters.

Test Plan:
- Pattern "ABAB" (len 4), overlap=1, text "ABABAB" -> match_pos 0 then 2, match_count=2, done=1. Same text with overlap=0 -> one match at position 0, count=1.
- Pattern "AABAAA" -> fail table 0,1,0,1,2,2 read back from kmp_fail_table; BUILD duration checked against a reference model.
- Pattern "AAAB", text "AAAAB" with text_valid always high -> text_ready drops during backtrack cycles; one match at position 1.
- Start with pat_len=0, and again with pat_len=PAT_MAX+1 -> err=1, done=1 on the next cycle, count=0, no match_valid pulse.
- CNT_W=4, pattern "A" (len 1), 20 'A' symbols with the last flagged -> 20 match_valid pulses at positions 0 to 19; match_count saturates at 15.
- Assert rst mid-SEARCH -> outputs zero immediately. Pulse abort mid-SEARCH -> IDLE next cycle, count is kept, and a subsequent start clears it.
